dp_debug_ctrl: RTL and testbench
================================

Name: dp_debug_ctrl

Overview:
Byte-command controller that sequences the pipelined MIPS Datapath.
- Takes bytes from the UART receiver.
- Loads a program into instruction memory through the Datapath write port (i_write_inst_mem / i_inst_mem_addr / i_inst_mem_data).
- Gates the Datapath enable for free-run or single-step, and issues Datapath soft resets.
- Sits between uart_rx and Datapath in the top level.

Parameters:
PC_BITS, 32, width of the instruction memory address (word index).
INSTRUCTION_BITS, 32, instruction width; must be 32 (four bytes per word).
BYTE_BITS, 8, received byte width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
i_rx_data  in  BYTE_BITS  received byte; valid only when i_rx_done=1
i_rx_done  in  1  one-cycle strobe, byte available
i_halt  in  1  Datapath reached a HALT instruction (level)
o_dp_enable  out  1  Datapath enable
o_dp_rst  out  1  Datapath soft-reset pulse, active-high
o_write_inst_mem  out  1  instruction-memory write strobe
o_inst_mem_addr  out  PC_BITS  write address (word index)
o_inst_mem_data  out  INSTRUCTION_BITS  write data
o_busy  out  1  high in any state other than IDLE
o_state  out  3  current state encoding, for debug

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, all outputs 0, byte counter=0, word counter=0, address=0. Reset mid-load or mid-run aborts at once; no partial word is written.
- State encodings: IDLE=0, LEN_LO=1, LEN_HI=2, LOAD=3, RUN=4, STEP=5, DPRST=6.
- IDLE accepts a byte only when i_rx_done=1:
  - 0x01 -> LEN_LO
  - 0x02 -> RUN
  - 0x03 -> STEP
  - 0x04 -> DPRST
  - any other byte is ignored; state stays IDLE.
- LEN_LO / LEN_HI: word count N received as two bytes, little-endian (16 bits).
  - After LEN_HI: N=0 -> IDLE with no write; otherwise -> LOAD, address=0, byte counter=0.
- LOAD: each received byte is shifted into the word little-endian: byte k goes to bits [8k+7:8k].
  - On the 4th byte, o_write_inst_mem=1 for exactly one cycle, the cycle after that byte's strobe.
  - During that cycle o_inst_mem_addr = current word index and o_inst_mem_data = assembled word.
  - After the write: address increments by 1, byte counter clears.
  - After the Nth write: -> IDLE. The write strobe and the return to IDLE occur in the same cycle.
  - Address wraps modulo 2^PC_BITS.
- RUN: o_dp_enable=1 starting the cycle after entry, held until i_halt is sampled high.
  - On that edge o_dp_enable goes to 0 and the state returns to IDLE.
  - If i_halt is already high on entry, enable is asserted for 0 cycles.
- STEP: o_dp_enable=1 for exactly one cycle, then IDLE. i_halt is ignored.
- DPRST: o_dp_rst=1 for exactly one cycle, then IDLE. o_dp_enable stays 0.
- i_rx_done outside IDLE/LEN/LOAD is ignored; bytes received during RUN/STEP/DPRST are dropped.
- o_write_inst_mem and o_dp_enable are never high in the same cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro: DP_CYCLE_COUNT_EN.
- Defined: adds output port o_cycle_count (32 bits).
  - Counts clk cycles in which o_dp_enable=1.
  - Cleared to 0 on rst and on entry to RUN; not cleared on STEP, so steps accumulate.
  - Saturates at 0xFFFFFFFF.
- Not defined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: rst=1 for 2 cycles, then release -> all outputs 0, o_state=0.
- Load two words: send 0x01,0x02,0x00, then bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE.
  - Exactly two write pulses: addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF.
  - o_busy falls in the cycle of the second write.
- Zero-length load: send 0x01,0x00,0x00 -> no write pulse; IDLE one cycle after the last byte.
- Run to halt: send 0x02; assert i_halt 10 cycles after o_dp_enable rises.
  - o_dp_enable is high exactly 10 cycles (11 if i_halt is sampled one cycle late; the bench checks the edge precisely).
  - o_cycle_count=10 when DP_CYCLE_COUNT_EN is defined.
- Step, reset and unknown command: send 0x03 twice, 0x04 once, and an unknown byte 0x7F.
  - Two isolated 1-cycle o_dp_enable pulses.
  - One 1-cycle o_dp_rst pulse.
  - 0x7F produces no output change.
- Abort mid-load: assert rst after 2 of 4 bytes of the first word.
  - No write occurs; state=IDLE.
  - A following full load starts writing at addr 0.

Source files
------------

// File: rtl/dp_debug_ctrl.sv
// Byte-command controller that loads instruction memory and sequences the pipelined MIPS Datapath.
// Optional cycle counter output o_cycle_count is enabled by defining DP_CYCLE_COUNT_EN.
module dp_debug_ctrl #(
  parameter int PC_BITS          = 32,
  parameter int INSTRUCTION_BITS = 32,
  parameter int BYTE_BITS        = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BYTE_BITS-1:0]        i_rx_data,
  input  logic                        i_rx_done,
  input  logic                        i_halt,
  output logic                        o_dp_enable,
  output logic                        o_dp_rst,
  output logic                        o_write_inst_mem,
  output logic [PC_BITS-1:0]          o_inst_mem_addr,
  output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
  output logic                        o_busy,
  output logic [2:0]                  o_state
`ifdef DP_CYCLE_COUNT_EN
  ,
  output logic [31:0]                 o_cycle_count
`endif
);

  localparam int LEN_BITS = 2 * BYTE_BITS;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    LOAD   = 3'd3,
    RUN    = 3'd4,
    STEP   = 3'd5,
    DPRST  = 3'd6
  } state_t;

  state_t state, state_next;

  logic [BYTE_BITS-1:0]        len_lo;
  logic [LEN_BITS-1:0]         len;
  logic [LEN_BITS-1:0]         word_cnt;
  logic [1:0]                  byte_cnt;
  logic [PC_BITS-1:0]          addr;
  logic [INSTRUCTION_BITS-1:0] word_reg;
  logic [INSTRUCTION_BITS-1:0] word_shift;
  logic                        write_next;
  logic                        enable_next;
  logic                        dp_rst_next;
  logic                        last_byte;
  logic                        last_word;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Bytes enter at the top so that after four shifts byte k sits in bits [8k+7:8k].
  always_comb begin
    state_next  = state;
    write_next  = 1'b0;
    enable_next = 1'b0;
    dp_rst_next = 1'b0;
    word_shift  = {i_rx_data, word_reg[INSTRUCTION_BITS-1:BYTE_BITS]};
    last_byte   = i_rx_done && (byte_cnt == 2'd3);
    last_word   = (word_cnt == len - LEN_BITS'(1));
    case (state)
      IDLE: begin
        if (i_rx_done) begin
          if      (i_rx_data == BYTE_BITS'(1)) state_next = LEN_LO;
          else if (i_rx_data == BYTE_BITS'(2)) state_next = RUN;
          else if (i_rx_data == BYTE_BITS'(3)) state_next = STEP;
          else if (i_rx_data == BYTE_BITS'(4)) state_next = DPRST;
        end
      end
      LEN_LO: begin
        if (i_rx_done) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (i_rx_done) state_next = ({i_rx_data, len_lo} == '0) ? IDLE : LOAD;
      end
      LOAD: begin
        if (last_byte) begin
          write_next = 1'b1;
          if (last_word) state_next = IDLE;
        end
      end
      RUN: begin
        if (i_halt) state_next  = IDLE;
        else        enable_next = 1'b1;
      end
      STEP: begin
        enable_next = 1'b1;
        state_next  = IDLE;
      end
      DPRST: begin
        dp_rst_next = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write address/data are captured on the last byte so they are stable during the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_dp_enable      <= 1'b0;
      o_dp_rst         <= 1'b0;
      o_write_inst_mem <= 1'b0;
      o_inst_mem_addr  <= '0;
      o_inst_mem_data  <= '0;
      o_busy           <= 1'b0;
      len_lo           <= '0;
      len              <= '0;
      word_cnt         <= '0;
      byte_cnt         <= '0;
      addr             <= '0;
      word_reg         <= '0;
    end else begin
      o_dp_enable      <= enable_next;
      o_dp_rst         <= dp_rst_next;
      o_write_inst_mem <= write_next;
      o_busy           <= (state_next != IDLE);
      case (state)
        LEN_LO: begin
          if (i_rx_done) len_lo <= i_rx_data;
        end
        LEN_HI: begin
          if (i_rx_done) begin
            len      <= {i_rx_data, len_lo};
            word_cnt <= '0;
            byte_cnt <= '0;
            addr     <= '0;
          end
        end
        LOAD: begin
          if (i_rx_done) begin
            word_reg <= word_shift;
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              o_inst_mem_addr <= addr;
              o_inst_mem_data <= word_shift;
              addr            <= addr + PC_BITS'(1);
              word_cnt        <= word_cnt + LEN_BITS'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_state = state;

`ifdef DP_CYCLE_COUNT_EN
  // Cleared on RUN entry only, so consecutive single steps accumulate.
  always_ff @(posedge clk) begin
    if (rst)
      o_cycle_count <= '0;
    else if (state == IDLE && state_next == RUN)
      o_cycle_count <= '0;
    else if (o_dp_enable && o_cycle_count != 32'hFFFF_FFFF)
      o_cycle_count <= o_cycle_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_dp_debug_ctrl.sv
// Self-checking bench for dp_debug_ctrl: per-cycle vector table plus hand-written run/step sequences.
// Define DP_CYCLE_COUNT_EN to also check the optional cycle counter.
module tb_dp_debug_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        halt;
  logic        dp_enable;
  logic        dp_rst;
  logic        write_inst_mem;
  logic [31:0] inst_mem_addr;
  logic [31:0] inst_mem_data;
  logic        busy;
  logic [2:0]  state;
`ifdef DP_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dp_debug_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .i_rx_data        (rx_data),
    .i_rx_done        (rx_done),
    .i_halt           (halt),
    .o_dp_enable      (dp_enable),
    .o_dp_rst         (dp_rst),
    .o_write_inst_mem (write_inst_mem),
    .o_inst_mem_addr  (inst_mem_addr),
    .o_inst_mem_data  (inst_mem_data),
    .o_busy           (busy),
    .o_state          (state)
`ifdef DP_CYCLE_COUNT_EN
    ,
    .o_cycle_count    (cycle_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        done;
    logic [7:0]  data;
    logic        halt;
    logic        en;
    logic        drst;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic [2:0]  st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic d, logic [7:0] b, logic h, logic en, logic drst,
                              logic wr, logic [31:0] a, logic [31:0] w, logic bsy, logic [2:0] st);
    vec_t v;
    v.rst = r; v.done = d; v.data = b; v.halt = h;
    v.en = en; v.drst = drst; v.wr = wr; v.addr = a; v.wdata = w; v.busy = bsy; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then step to the following negedge where outputs are sampled.
  task automatic applyStimulus(input vec_t v);
    rst     = v.rst;
    rx_done = v.done;
    rx_data = v.data;
    halt    = v.halt;
    @(negedge clk);
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    check($sformatf("row%0d dp_enable", idx), {31'd0, dp_enable}, {31'd0, v.en});
    check($sformatf("row%0d dp_rst", idx), {31'd0, dp_rst}, {31'd0, v.drst});
    check($sformatf("row%0d write", idx), {31'd0, write_inst_mem}, {31'd0, v.wr});
    check($sformatf("row%0d busy", idx), {31'd0, busy}, {31'd0, v.busy});
    check($sformatf("row%0d state", idx), {29'd0, state}, {29'd0, v.st});
    if (v.wr) begin
      check($sformatf("row%0d addr", idx), inst_mem_addr, v.addr);
      check($sformatf("row%0d data", idx), inst_mem_data, v.wdata);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; rx_done = 1'b0; rx_data = 8'h00; halt = 1'b0;
  endtask

  initial begin
    int wait_cycles;
    int high_cycles;

    rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; halt = 1'b0;

    //           rst done data   halt en drst wr addr  data          busy st
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0));
    // two-word load, with one gap cycle between bytes
    tbl.push_back(mk(0, 1, 8'h01, 0, 0, 0, 0, 0, 0,            1, 1));
    tbl.push_back(mk(0, 1, 8'h02, 0, 0, 0, 0, 0, 0,            1, 2));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(0, 1, 8'h78, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(0, 1, 8'h56, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(0, 1, 8'h34, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(0, 1, 8'h12, 0, 0, 0, 1, 0, 32'h12345678, 1, 3));
    tbl.push_back(mk(0, 1, 8'hEF, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(0, 1, 8'hBE, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(0, 1, 8'hAD, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(0, 1, 8'hDE, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0));
    // zero-length load, then unknown command
    tbl.push_back(mk(0, 1, 8'h01, 0, 0, 0, 0, 0, 0,            1, 1));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 0,            1, 2));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 1, 8'h7F, 0, 0, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0));
    // two steps (byte 0x04 during STEP is dropped), then a datapath reset
    tbl.push_back(mk(0, 1, 8'h03, 0, 0, 0, 0, 0, 0,            1, 5));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 1, 8'h03, 0, 0, 0, 0, 0, 0,            1, 5));
    tbl.push_back(mk(0, 1, 8'h04, 0, 1, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 1, 8'h04, 0, 0, 0, 0, 0, 0,            1, 6));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0));
    // RUN with halt already high: zero enable cycles
    tbl.push_back(mk(0, 1, 8'h02, 1, 0, 0, 0, 0, 0,            1, 4));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0));
    // STEP ignores halt
    tbl.push_back(mk(0, 1, 8'h03, 1, 0, 0, 0, 0, 0,            1, 5));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0));
    // abort mid-load after two bytes, stale byte ignored, then one-word reload at addr 0
    tbl.push_back(mk(0, 1, 8'h01, 0, 0, 0, 0, 0, 0,            1, 1));
    tbl.push_back(mk(0, 1, 8'h01, 0, 0, 0, 0, 0, 0,            1, 2));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(0, 1, 8'h11, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(0, 1, 8'h22, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 1, 8'hD4, 0, 0, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 0, 0, 0, 0, 0,            1, 1));
    tbl.push_back(mk(0, 1, 8'h01, 0, 0, 0, 0, 0, 0,            1, 2));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(0, 1, 8'hD4, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(0, 1, 8'hC3, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(0, 1, 8'hB2, 0, 0, 0, 0, 0, 0,            1, 3));
    tbl.push_back(mk(0, 1, 8'hA1, 0, 0, 0, 1, 0, 32'hA1B2C3D4, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0,            0, 0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput(i, tbl[i]);
    end

    // Run to halt: halt is raised so that the edge ending the 10th enable cycle samples it.
    idle_inputs();
    rx_done = 1'b1; rx_data = 8'h02;
    @(negedge clk);
    idle_inputs();
    check("run_entry_state", {29'd0, state}, 32'd4);
    check("run_entry_enable", {31'd0, dp_enable}, 32'd0);
    wait_cycles = 0;
    while (dp_enable !== 1'b1 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    check("run_enable_latency", wait_cycles, 32'd1);
    high_cycles = (dp_enable === 1'b1) ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (dp_enable === 1'b1) high_cycles++;
      check("run_no_write", {31'd0, write_inst_mem}, 32'd0);
    end
    halt = 1'b1;
    @(negedge clk);
    check("run_halt_enable", {31'd0, dp_enable}, 32'd0);
    check("run_halt_state", {29'd0, state}, 32'd0);
    check("run_halt_busy", {31'd0, busy}, 32'd0);
    check("run_enable_cycles", high_cycles, 32'd10);
`ifdef DP_CYCLE_COUNT_EN
    check("run_cycle_count", cycle_count, 32'd10);
`endif
    halt = 1'b0;
    @(negedge clk);
    check("run_after_enable", {31'd0, dp_enable}, 32'd0);

    // A step after the run accumulates onto the counter.
    rx_done = 1'b1; rx_data = 8'h03;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("step_after_run_enable", {31'd0, dp_enable}, 32'd1);
    @(negedge clk);
    check("step_after_run_off", {31'd0, dp_enable}, 32'd0);
`ifdef DP_CYCLE_COUNT_EN
    check("step_cycle_count", cycle_count, 32'd11);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
